// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one stop bit.
// Each bit is held for a programmable number of clock cycles.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      clk_strc,
  input  logic                      rst_strc,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int unsigned IdxWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                    state_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic [IdxWidth-1:0]       idx_q;

  logic                      bit_end;
  logic                      accept;
  logic [PRESCALE_WIDTH-1:0] presc_in;
  logic                      par_in;

  assign bit_end  = (cnt_q == presc_q - PRESCALE_WIDTH'(1));
  // A new word is taken when idle, or on the last stop cycle for gapless back-to-back frames.
  assign accept   = data_valid && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
  assign presc_in = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
  assign par_in   = par_typ ? ~^p_data : ^p_data;

  always_ff @(posedge clk_strc or negedge rst_strc) begin
    if (!rst_strc) begin
      state_q   <= StIdle;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      presc_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
    end else if (accept) begin
      state_q   <= StStart;
      data_q    <= p_data;
      par_en_q  <= par_en;
      par_bit_q <= par_in;
      presc_q   <= presc_in;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_out    <= 1'b0;
      busy      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= StData;
            tx_out  <= data_q[0];
            data_q  <= data_q >> 1;
          end else begin
            cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == IdxWidth'(DATA_WIDTH - 1)) begin
              if (par_en_q) begin
                state_q <= StParity;
                tx_out  <= par_bit_q;
              end else begin
                state_q <= StStop;
                tx_out  <= 1'b1;
              end
            end else begin
              idx_q  <= idx_q + IdxWidth'(1);
              tx_out <= data_q[0];
              data_q <= data_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
          end
        end
        StParity: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StStop;
            tx_out  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            busy    <= 1'b0;
            tx_out  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          tx_out  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a queue of expected line levels, one entry per clock cycle,
// built from the frame format and compared against tx_out/busy every cycle.
module tb_uart_tx_frame;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          dv;
  logic          pe;
  logic          pt;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;

  int   total;
  int   bad;
  bit   mon_en;
  logic exp_q[$];

  uart_tx_frame #(
    .DATA_WIDTH     (DW),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk_strc   (clk),
    .rst_strc   (rst),
    .p_data     (p_data),
    .data_valid (dv),
    .par_en     (pe),
    .par_typ    (pt),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One line level per cycle for a whole frame.
  function automatic void push_frame(input logic [DW-1:0] d, input logic e, input logic t,
                                     input logic [PW-1:0] ps);
    int   n;
    logic par;
    logic bits[$];
    n = (ps == 0) ? 1 : int'(ps);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    par = (($countones(d) % 2) == 1) ? 1'b1 : 1'b0;
    if (t) par = ~par;
    if (e) bits.push_back(par);
    bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < n; k++) exp_q.push_back(bits[i]);
  endfunction

  // Head of exp_q is the level on the line during the current cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0 && dv === 1'b1) push_frame(p_data, pe, pt, prescale);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("tx_out", 32'(tx_out), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd1);
      check("busy", 32'(busy), (exp_q.size() > 0) ? 32'd1 : 32'd0);
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic e, input logic t,
                      input logic [PW-1:0] ps);
    @(negedge clk);
    p_data   = d;
    pe       = e;
    pt       = t;
    prescale = ps;
    dv       = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    bit done;
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else begin
        done = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(done), 32'd1);
  endtask

  int n;
  int n1;

  initial begin
    total    = 0;
    bad      = 0;
    mon_en   = 1'b0;
    dv       = 1'b0;
    p_data   = '0;
    pe       = 1'b0;
    pt       = 1'b0;
    prescale = '0;
    rst      = 1'b1;
    #1 rst   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx_out), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;

    send(8'hA5, 1'b1, 1'b0, 6'd1);
    wait_idle(n);
    check("busy_len_a5", n, 11);

    send(8'h01, 1'b1, 1'b1, 6'd4);
    wait_idle(n);
    check("busy_len_01_p4", n, 44);

    send(8'hFF, 1'b0, 1'b0, 6'd2);
    wait_idle(n);
    check("busy_len_ff_p2", n, 20);

    // Second word presented on the final stop cycle of the first.
    send(8'h55, 1'b0, 1'b0, 6'd1);
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n1++;
    end
    p_data = 8'h0F;
    dv     = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
    wait_idle(n);
    check("busy_len_b2b", n1 + n, 20);

    // Junk during DATA must be ignored.
    send(8'h00, 1'b1, 1'b0, 6'd2);
    repeat (6) @(negedge clk);
    p_data   = 8'h00;
    prescale = 6'd8;
    dv       = 1'b1;
    repeat (3) @(negedge clk);
    dv = 1'b0;
    wait_idle(n);
    check("busy_len_midframe", n + 9, 22);
    repeat (4) @(negedge clk);
    check("no_second_frame", 32'(busy), 32'd0);

    send(8'h3C, 1'b1, 1'b1, 6'd0);
    wait_idle(n);
    check("busy_len_presc0", n, 11);

    // Asynchronous reset in the middle of DATA.
    send(8'h00, 1'b0, 1'b0, 6'd4);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx_out), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_tx", 32'(tx_out), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    repeat (3000) begin
      @(negedge clk);
      dv       = ($urandom_range(0, 3) == 0);
      p_data   = DW'($urandom);
      pe       = 1'($urandom_range(0, 1));
      pt       = 1'($urandom_range(0, 1));
      prescale = PW'($urandom_range(0, 4));
    end
    dv = 1'b0;
    wait_idle(n);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
